// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: de-serialises MSB-first channel words (1-SCK WS delay) into a FWFT FIFO.
// Define I2S_RX_SYNC_EN to put a 2-flop synchroniser ahead of the pin capture flops.
module i2s_slave_rx #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [1:0]                    dat_len_i,
  input  logic                          i2s_sck_i,
  input  logic                          i2s_ws_i,
  input  logic                          i2s_sd_i,
  output logic [DATA_WIDTH-1:0]         rx_data_o,
  output logic                          rx_chan_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          ovf_o,
  input  logic                          clr_ovf_i
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = DATA_WIDTH + 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RECV = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [2:0] pin_q, pin_d;
  logic       sck_s, ws_s, sd_s;
  logic       sck_dly_q, sck_dly_d;
  logic       ws_d_q, ws_d_d;
  logic       sck_rise, boundary;

  logic [DATA_WIDTH-1:0] sr_q, sr_d, sr_n, word;
  logic [5:0]            bit_cnt_q, bit_cnt_d, cnt_n;
  logic [5:0]            cur_len_q, cur_len_d, new_len;
  logic [2:0]            len_units;
  logic                  take, push;

  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            full, not_empty, pop, push_ok;

`ifdef I2S_RX_SYNC_EN
  logic [2:0] meta1_q, meta1_d, meta2_q, meta2_d;

  always_comb begin
    meta1_d = {i2s_sck_i, i2s_ws_i, i2s_sd_i};
    meta2_d = meta1_q;
    pin_d   = meta2_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta1_q <= '0;
      meta2_q <= '0;
    end else begin
      meta1_q <= meta1_d;
      meta2_q <= meta2_d;
    end
  end
`else
  always_comb begin
    pin_d = {i2s_sck_i, i2s_ws_i, i2s_sd_i};
  end
`endif

  always_comb begin
    {sck_s, ws_s, sd_s} = pin_q;
    sck_dly_d = sck_s;
    sck_rise  = sck_s & ~sck_dly_q;
    boundary  = sck_rise & (ws_s != ws_d_q);
    len_units = {1'b0, dat_len_i} + 3'd1;
    new_len   = {len_units, 3'b000};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en_i) state_d = SYNC;
      SYNC:    if (!en_i) state_d = IDLE;
               else if (boundary) state_d = RECV;
      RECV:    if (!en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The boundary edge still carries the LSB of the ending slot, so it is shifted
  // in before the word is justified and pushed.
  always_comb begin
    ws_d_d    = sck_rise ? ws_s : ws_d_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    cur_len_d = cur_len_q;
    push      = 1'b0;
    take      = bit_cnt_q < cur_len_q;
    sr_n      = take ? {sr_q[DATA_WIDTH-2:0], sd_s} : sr_q;
    cnt_n     = take ? bit_cnt_q + 6'd1 : bit_cnt_q;
    word      = sr_n << (cur_len_q - cnt_n);
    if (state_q == SYNC && en_i && boundary) begin
      sr_d      = '0;
      bit_cnt_d = '0;
      cur_len_d = new_len;
    end else if (state_q == RECV && en_i && sck_rise) begin
      if (boundary) begin
        push      = 1'b1;
        sr_d      = '0;
        bit_cnt_d = '0;
        cur_len_d = new_len;
      end else begin
        sr_d      = sr_n;
        bit_cnt_d = cnt_n;
      end
    end
  end

  always_comb begin
    full      = (cnt_q == FULL_CNT);
    not_empty = (cnt_q != '0);
    pop       = not_empty & rx_ready_i;
    push_ok   = push & (~full | pop);
    mem_d     = mem_q;
    if (push_ok) mem_d[wr_q] = {ws_d_q, word};
    wr_d = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (push & ~push_ok) ovf_d = 1'b1;
    else if (clr_ovf_i)  ovf_d = 1'b0;
    else                 ovf_d = ovf_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pin_q     <= '0;
      sck_dly_q <= 1'b0;
      ws_d_q    <= 1'b0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      cur_len_q <= '0;
      mem_q     <= '{default: '0};
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pin_q     <= pin_d;
      sck_dly_q <= sck_dly_d;
      ws_d_q    <= ws_d_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      cur_len_q <= cur_len_d;
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    rx_valid_o = not_empty;
    rx_data_o  = not_empty ? mem_q[rd_q][DATA_WIDTH-1:0] : '0;
    rx_chan_o  = not_empty & mem_q[rd_q][DATA_WIDTH];
    fifo_cnt_o = cnt_q;
    ovf_o      = ovf_q;
  end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: drives an I2S master pin model and checks the FIFO side.
`timescale 1ns/1ps
module tb_i2s_slave_rx;

`ifdef I2S_RX_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic [1:0]  dat_len_i = 2'd0;
  logic        i2s_sck_i = 1'b0;
  logic        i2s_ws_i = 1'b0;
  logic        i2s_sd_i = 1'b0;
  logic [31:0] rx_data_o;
  logic        rx_chan_o;
  logic        rx_valid_o;
  logic        rx_ready_i = 1'b0;
  logic [3:0]  fifo_cnt_o;
  logic        ovf_o;
  logic        clr_ovf_i = 1'b0;

  int total = 0;
  int bad = 0;
  logic prev_lsb = 1'b0;
  logic [32:0] popq [$];

  i2s_slave_rx #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .dat_len_i(dat_len_i),
    .i2s_sck_i(i2s_sck_i), .i2s_ws_i(i2s_ws_i), .i2s_sd_i(i2s_sd_i),
    .rx_data_o(rx_data_o), .rx_chan_o(rx_chan_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .fifo_cnt_o(fifo_cnt_o), .ovf_o(ovf_o),
    .clr_ovf_i(clr_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i)
    if (rx_valid_o && rx_ready_i) popq.push_back({rx_chan_o, rx_data_o});

  initial begin
    #900_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] wv(input int k);
    return 16'hA000 + 16'(k) * 16'h0111;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sbit(input logic ws_v, input logic sd_v, input bit pop_at_push);
    i2s_sck_i = 1'b0; i2s_ws_i = ws_v; i2s_sd_i = sd_v;
    repeat (4) @(posedge clk_i);
    #1 i2s_sck_i = 1'b1;
    if (pop_at_push) begin
      repeat (LAT-1) @(posedge clk_i);
      #1 rx_ready_i = 1'b1;
      @(posedge clk_i);
      #1 rx_ready_i = 1'b0;
      repeat (4-LAT) @(posedge clk_i);
    end else begin
      repeat (4) @(posedge clk_i);
    end
    #1;
  endtask

  // act: 0 none, 1 drop en, 2 raise en, 3 reset pulse, 4 pop aligned with bit-0 push
  task automatic send_word(input logic ws_v, input logic [31:0] word, input int slot,
                           input int act_bit, input int act);
    for (int b = 0; b < slot; b++) begin
      logic bsd;
      if (b == act_bit) begin
        case (act)
          1: en_i = 1'b0;
          2: en_i = 1'b1;
          3: begin
            i2s_sck_i = 1'b0;
            chk("rst pre valid", rx_valid_o, 1);
            rst_i = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
            chk("rst valid", rx_valid_o, 0);
            chk("rst cnt", fifo_cnt_o, 0);
            chk("rst data", rx_data_o, 0);
            chk("rst chan", rx_chan_o, 0);
            chk("rst ovf", ovf_o, 0);
            @(posedge clk_i);
            #1 rst_i = 1'b0;
          end
          default: ;
        endcase
      end
      bsd = (b == 0) ? prev_lsb : word[slot-b];
      sbit(ws_v, bsd, (b == act_bit) && (act == 4));
    end
    prev_lsb = word[0];
  endtask

  task automatic start(input logic [1:0] len);
    rst_i = 1'b1; en_i = 1'b0; rx_ready_i = 1'b0; clr_ovf_i = 1'b0;
    i2s_sck_i = 1'b0; i2s_ws_i = 1'b1; i2s_sd_i = 1'b0; prev_lsb = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    sbit(1'b1, 1'b0, 1'b0);
    sbit(1'b1, 1'b0, 1'b0);
    dat_len_i = len;
    en_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic pop_chk(input string tag, input logic chan, input logic [31:0] data);
    @(negedge clk_i);
    chk({tag, " data"}, rx_data_o, data);
    chk({tag, " chan"}, rx_chan_o, chan);
    rx_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rx_ready_i = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset valid", rx_valid_o, 0);
    chk("reset cnt", fifo_cnt_o, 0);
    chk("reset ovf", ovf_o, 0);
    chk("reset data", rx_data_o, 0);

    // stereo 16-bit words in 32-bit slots, streaming pop
    start(2'd1);
    rx_ready_i = 1'b1;
    popq.delete();
    send_word(1'b0, 32'hA5C3_0000, 32, -1, 0);
    send_word(1'b1, 32'h1234_0000, 32, -1, 0);
    send_word(1'b0, 32'h0000_0000, 32, -1, 0);
    @(negedge clk_i);
    chk("stereo count", popq.size(), 2);
    chk("stereo left", popq[0], {1'b0, 32'h0000_A5C3});
    chk("stereo right", popq[1], {1'b1, 32'h0000_1234});
    chk("stereo empty", rx_valid_o, 0);

    // 24-bit word in 32-bit slot, trailing bits ignored
    start(2'd2);
    send_word(1'b0, 32'hDEAD_BEEF, 32, -1, 0);
    send_word(1'b1, 32'h0, 32, -1, 0);
    @(negedge clk_i);
    chk("len24 valid", rx_valid_o, 1);
    chk("len24 cnt", fifo_cnt_o, 1);
    chk("len24 data", rx_data_o, 32'h00DE_ADBE);
    chk("len24 chan", rx_chan_o, 0);

    // short slot: 32-bit word from a 16-bit slot is left-justified
    start(2'd3);
    send_word(1'b0, 32'h0000_BEEF, 16, -1, 0);
    send_word(1'b1, 32'h0, 16, -1, 0);
    @(negedge clk_i);
    chk("short data", rx_data_o, 32'hBEEF_0000);
    chk("short chan", rx_chan_o, 0);

    // overflow: 10 words into 8 entries
    start(2'd1);
    for (int k = 0; k < 10; k++) send_word(1'(k % 2), {16'h0, wv(k)}, 16, -1, 0);
    send_word(1'b0, 32'h0, 16, -1, 0);
    @(negedge clk_i);
    chk("ovf cnt", fifo_cnt_o, 8);
    chk("ovf flag", ovf_o, 1);
    for (int k = 0; k < 8; k++) pop_chk("ovf drain", 1'(k % 2), {16'h0, wv(k)});
    @(negedge clk_i);
    chk("ovf drained", rx_valid_o, 0);
    chk("ovf sticky", ovf_o, 1);
    clr_ovf_i = 1'b1;
    @(posedge clk_i);
    #1 clr_ovf_i = 1'b0;
    @(negedge clk_i);
    chk("ovf cleared", ovf_o, 0);

    // full FIFO with a pop in the push cycle
    start(2'd1);
    for (int k = 0; k < 9; k++) send_word(1'(k % 2), {16'h0, wv(k)}, 16, -1, 0);
    @(negedge clk_i);
    chk("full cnt", fifo_cnt_o, 8);
    send_word(1'b1, {16'h0, wv(9)}, 16, 0, 4);
    @(negedge clk_i);
    chk("full pop cnt", fifo_cnt_o, 8);
    chk("full pop ovf", ovf_o, 0);
    for (int k = 1; k < 9; k++) pop_chk("full drain", 1'(k % 2), {16'h0, wv(k)});

    // enable dropped mid-word, re-enabled mid-frame
    start(2'd1);
    send_word(1'b0, 32'h1111, 16, -1, 0);
    send_word(1'b1, 32'h2222, 16, 8, 1);
    send_word(1'b0, 32'h3333, 16, 5, 2);
    send_word(1'b1, 32'h4444, 16, -1, 0);
    send_word(1'b0, 32'h5555, 16, -1, 0);
    send_word(1'b1, 32'h6666, 16, -1, 0);
    @(negedge clk_i);
    chk("en cnt", fifo_cnt_o, 3);
    pop_chk("en w0", 1'b0, 32'h1111);
    pop_chk("en w1", 1'b1, 32'h4444);
    pop_chk("en w2", 1'b0, 32'h5555);

    // reset mid-word, then realignment through SYNC
    send_word(1'b0, 32'h7777, 16, 6, 3);
    send_word(1'b1, 32'h8888, 16, -1, 0);
    send_word(1'b0, 32'h9999, 16, -1, 0);
    send_word(1'b1, 32'h0, 16, -1, 0);
    @(negedge clk_i);
    chk("rst realign cnt", fifo_cnt_o, 2);
    pop_chk("rst r0", 1'b1, 32'h8888);
    pop_chk("rst r1", 1'b0, 32'h9999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
